// File: rtl/ced_pkg.sv
// rtl/ced_pkg.sv - shared constants, FSM state type and parity helpers for the AES CED monitor
package ced_pkg;

  localparam int FN_SB = 0;
  localparam int FN_SR = 1;
  localparam int FN_MX = 2;
  localparam int FN_KX = 3;

  localparam logic [3:0] NO_FAULT_ROUND = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MONITOR = 2'd1,
    ST_DONE    = 2'd2
  } ced_state_e;

  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

  function automatic logic [15:0] state_par16(input logic [127:0] s);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) p[i] = byte_par(s[8*i +: 8]);
    return p;
  endfunction

  // Byte i = 4*col + row, so a column is one contiguous 32-bit slice.
  function automatic logic [7:0] col_xor(input logic [127:0] s, input int col);
    return s[32*col +: 8] ^ s[32*col+8 +: 8] ^ s[32*col+16 +: 8] ^ s[32*col+24 +: 8];
  endfunction

endpackage

// File: rtl/ced_check_comb.sv
// rtl/ced_check_comb.sv - combinational per-function invariant checks with round gating
module ced_check_comb
  import ced_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic [3:0]   round_idx,
  input  logic [15:0]  parity_pred,
  input  logic [127:0] data_out_sb,
  input  logic [127:0] data_in_sr,
  input  logic [127:0] data_out_sr,
  input  logic [127:0] data_in_mx,
  input  logic [127:0] data_out_mx,
  input  logic [127:0] data_in_kx,
  input  logic [127:0] data_out_kx,
  input  logic [127:0] round_key,
  output logic [3:0]   err
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  logic [15:0] sr_in_p;
  logic [15:0] sr_perm_p;
  logic [3:0]  raw;

  always_comb begin
    sr_in_p   = state_par16(data_in_sr);
    sr_perm_p = '0;
    // out(row r, col c) is sourced from in(row r, col (c+r) mod 4)
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_perm_p[4*c+r] = sr_in_p[4*((c+r)%4)+r];
      end
    end

    raw         = '0;
    raw[FN_SB]  = |(state_par16(data_out_sb) ^ parity_pred);
    raw[FN_SR]  = |(state_par16(data_out_sr) ^ sr_perm_p);
    for (int c = 0; c < 4; c++) begin
      if (col_xor(data_out_mx, c) != col_xor(data_in_mx, c)) raw[FN_MX] = 1'b1;
    end
    raw[FN_KX]  = |(state_par16(data_out_kx) ^ state_par16(data_in_kx) ^ state_par16(round_key));

    err = '0;
    if (round_idx == 4'd0) begin
      err[FN_KX] = raw[FN_KX];
    end else if (round_idx < LAST_ROUND) begin
      err = raw;
    end else if (round_idx == LAST_ROUND) begin
      err        = raw;
      err[FN_MX] = 1'b0;
    end
  end

endmodule

// File: rtl/ced_fault_monitor.sv
// rtl/ced_fault_monitor.sv - AES CED monitor top: FSM, one-stage check pipeline, sticky fault flags
// Optional CED_FAULT_COUNT_EN adds a saturating fault_count output.
module ced_fault_monitor
  import ced_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int CNT_W      = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         finish,
  input  logic         round_valid,
  input  logic [3:0]   round_idx,
  input  logic [15:0]  parity_pred,
  input  logic [127:0] data_in_sb,
  input  logic [127:0] data_out_sb,
  input  logic [127:0] data_in_sr,
  input  logic [127:0] data_out_sr,
  input  logic [127:0] data_in_mx,
  input  logic [127:0] data_out_mx,
  input  logic [127:0] data_in_kx,
  input  logic [127:0] data_out_kx,
  input  logic [127:0] round_key,
  output logic         busy,
  output logic         fault_detected,
  output logic [3:0]   fault_location,
  output logic [3:0]   first_fault_round
`ifdef CED_FAULT_COUNT_EN
  ,
  output logic [CNT_W-1:0] fault_count
`endif
);

  ced_state_e state_q, state_d;
  logic [3:0] err_comb, err_q, err_d, round_q, round_d;
  logic       det_q, det_d, sample_en, hit;
  logic [3:0] loc_q, loc_d, first_q, first_d;

  // S-box input is not covered by any invariant; parity prediction stands in for it.
  logic unused_sb_in;
  assign unused_sb_in = ^data_in_sb;

  ced_check_comb #(.NUM_ROUNDS(NUM_ROUNDS)) u_check (
    .round_idx   (round_idx),
    .parity_pred (parity_pred),
    .data_out_sb (data_out_sb),
    .data_in_sr  (data_in_sr),
    .data_out_sr (data_out_sr),
    .data_in_mx  (data_in_mx),
    .data_out_mx (data_out_mx),
    .data_in_kx  (data_in_kx),
    .data_out_kx (data_out_kx),
    .round_key   (round_key),
    .err         (err_comb)
  );

  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_MONITOR;
      ST_MONITOR: if (!start && finish) state_d = ST_DONE;
      ST_DONE:    if (start) state_d = ST_MONITOR;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_MONITOR);
    sample_en = busy && round_valid && !start;
  end

  // The sample taken alongside finish still drains through err_q into the sticky flags.
  always_comb begin
    err_d   = sample_en ? err_comb : 4'h0;
    round_d = round_idx;
    hit     = |err_q;
    det_d   = det_q | hit;
    loc_d   = loc_q | err_q;
    first_d = (hit && first_q == NO_FAULT_ROUND) ? round_q : first_q;
    if (start) begin
      err_d   = 4'h0;
      det_d   = 1'b0;
      loc_d   = 4'h0;
      first_d = NO_FAULT_ROUND;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      err_q   <= 4'h0;
      round_q <= 4'h0;
      det_q   <= 1'b0;
      loc_q   <= 4'h0;
      first_q <= NO_FAULT_ROUND;
    end else begin
      err_q   <= err_d;
      round_q <= round_d;
      det_q   <= det_d;
      loc_q   <= loc_d;
      first_q <= first_d;
    end
  end

  assign fault_detected    = det_q;
  assign fault_location    = loc_q;
  assign first_fault_round = first_q;

`ifdef CED_FAULT_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start)                  cnt_d = '0;
    else if (hit && !(&cnt_q))  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign fault_count = cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_ced_fault_monitor.sv
// tb/tb_ced_fault_monitor.sv - self-checking bench for ced_fault_monitor driven by a real AES-128 trace
module tb_ced_fault_monitor;

  localparam int NR = 10;
  localparam int CW = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset, start, finish, round_valid;
  logic [3:0]   round_idx;
  logic [15:0]  parity_pred;
  logic [127:0] data_in_sb, data_out_sb, data_in_sr, data_out_sr;
  logic [127:0] data_in_mx, data_out_mx, data_in_kx, data_out_kx, round_key;
  logic         busy, fault_detected;
  logic [3:0]   fault_location, first_fault_round;
`ifdef CED_FAULT_COUNT_EN
  logic [CW-1:0] fault_count;
`endif

  ced_fault_monitor #(.NUM_ROUNDS(NR), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .finish(finish),
    .round_valid(round_valid), .round_idx(round_idx), .parity_pred(parity_pred),
    .data_in_sb(data_in_sb), .data_out_sb(data_out_sb),
    .data_in_sr(data_in_sr), .data_out_sr(data_out_sr),
    .data_in_mx(data_in_mx), .data_out_mx(data_out_mx),
    .data_in_kx(data_in_kx), .data_out_kx(data_out_kx),
    .round_key(round_key),
    .busy(busy), .fault_detected(fault_detected),
    .fault_location(fault_location), .first_fault_round(first_fault_round)
`ifdef CED_FAULT_COUNT_EN
    , .fault_count(fault_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [127:0] a_sb_in[11], a_sb_out[11], a_sr_in[11], a_sr_out[11];
  logic [127:0] a_mx_in[11], a_mx_out[11], a_kx_in[11], a_kx_out[11], a_rk[11];
  logic [15:0]  a_pp[11];

  logic       m_act, m_det;
  logic [3:0] m_loc, m_first, p_err, p_round, cur_mask;
  int         m_cnt;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = 8'h00;
    if (a != 8'h00) begin
      b = a;
      for (int i = 0; i < 253; i++) b = gmul(b, a);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [15:0] par16(input logic [127:0] s);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) p[i] = ^s[8*i +: 8];
    return p;
  endfunction

  // Which detected functions are expected to survive the round gating
  function automatic logic [3:0] gate(input logic [3:0] m, input int r);
    if (r == 0)  return m & 4'b1000;
    if (r < NR)  return m;
    if (r == NR) return m & 4'b1011;
    return 4'h0;
  endfunction

  function automatic logic [9:0] obs();
    return {busy, fault_detected, fault_location, first_fault_round};
  endfunction

  task automatic build_aes();
    logic [7:0]   ek[176];
    logic [7:0]   t[4];
    logic [7:0]   rc, t0, a0, a1, a2, a3;
    logic [127:0] s, o;
    for (int i = 0; i < 16; i++) ek[i] = 8'(i);
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) t[j] = ek[i-4+j];
      if (i % 16 == 0) begin
        t0 = t[0];
        t[0] = sbox(t[1]) ^ rc;
        t[1] = sbox(t[2]);
        t[2] = sbox(t[3]);
        t[3] = sbox(t0);
        rc = xt(rc);
      end
      for (int j = 0; j < 4; j++) ek[i+j] = ek[i-16+j] ^ t[j];
    end
    for (int r = 0; r <= NR; r++)
      for (int i = 0; i < 16; i++) a_rk[r][8*i +: 8] = ek[16*r+i];
    for (int i = 0; i < 16; i++) s[8*i +: 8] = 8'(17 * i);
    a_sb_in[0] = '0; a_sb_out[0] = '0; a_sr_in[0] = '0; a_sr_out[0] = '0;
    a_mx_in[0] = '0; a_mx_out[0] = '0; a_pp[0] = '0;
    a_kx_in[0] = s;
    s = s ^ a_rk[0];
    a_kx_out[0] = s;
    for (int r = 1; r <= NR; r++) begin
      a_sb_in[r] = s;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
      s = o;
      a_sb_out[r] = s;
      a_pp[r] = par16(s);
      a_sr_in[r] = s;
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) o[8*(4*c+w) +: 8] = s[8*(4*((c+w)%4)+w) +: 8];
      s = o;
      a_sr_out[r] = s;
      a_mx_in[r] = s;
      if (r < NR) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
          o[32*c +: 8]    = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          o[32*c+8 +: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          o[32*c+16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          o[32*c+24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        s = o;
      end
      a_mx_out[r] = s;
      a_kx_in[r] = s;
      s = s ^ a_rk[r];
      a_kx_out[r] = s;
    end
  endtask

  // Presents round r's trace, with one single-bit flip on a bus of each function in fmask.
  task automatic drive_round(input int r, input logic [3:0] fmask);
    int d;
    int bi;
    d = (r > NR) ? 5 : r;
    round_valid = 1'b1;
    round_idx   = 4'(r);
    data_in_sb  = a_sb_in[d];  data_out_sb = a_sb_out[d];
    data_in_sr  = a_sr_in[d];  data_out_sr = a_sr_out[d];
    data_in_mx  = a_mx_in[d];  data_out_mx = a_mx_out[d];
    data_in_kx  = a_kx_in[d];  data_out_kx = a_kx_out[d];
    round_key   = a_rk[d];     parity_pred = a_pp[d];
    cur_mask    = fmask;
    bi = int'($urandom_range(127, 0));
    if (fmask[0]) begin
      if ($urandom_range(1, 0) == 0) data_out_sb[bi] = ~data_out_sb[bi];
      else parity_pred[bi/8] = ~parity_pred[bi/8];
    end
    if (fmask[1]) begin
      if ($urandom_range(1, 0) == 0) data_out_sr[bi] = ~data_out_sr[bi];
      else data_in_sr[bi] = ~data_in_sr[bi];
    end
    if (fmask[2]) begin
      if ($urandom_range(1, 0) == 0) data_out_mx[bi] = ~data_out_mx[bi];
      else data_in_mx[bi] = ~data_in_mx[bi];
    end
    if (fmask[3]) begin
      case ($urandom_range(2, 0))
        0:       data_out_kx[bi] = ~data_out_kx[bi];
        1:       data_in_kx[bi]  = ~data_in_kx[bi];
        default: round_key[bi]   = ~round_key[bi];
      endcase
    end
  endtask

  task automatic idle();
    round_valid = 1'b0;
    cur_mask    = 4'h0;
    start       = 1'b0;
    finish      = 1'b0;
  endtask

  task automatic model_clear();
    m_det = 1'b0; m_loc = 4'h0; m_first = 4'hF; m_cnt = 0; p_err = 4'h0; p_round = 4'h0;
  endtask

  // Advances the reference model on the inputs in place, then one clock edge.
  task automatic step();
    if (!reset) begin
      m_act = 1'b0;
      model_clear();
    end else if (start) begin
      m_act = 1'b1;
      model_clear();
    end else begin
      if (p_err != 4'h0) begin
        m_det = 1'b1;
        m_loc = m_loc | p_err;
        if (m_first == 4'hF) m_first = p_round;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
      p_err   = (m_act && round_valid) ? gate(cur_mask, int'(round_idx)) : 4'h0;
      p_round = round_idx;
      if (finish) m_act = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_round(0, 4'h0);
    idle();
    step();
    step();
    checks++;
    if (obs() !== 10'b00_0000_1111) begin
      errors++; $display("FAIL reset: got %b expected %b", obs(), 10'b00_0000_1111);
    end
`ifdef CED_FAULT_COUNT_EN
    checks++;
    if (fault_count !== CW'(0)) begin errors++; $display("FAIL reset_count: got %0d expected 0", fault_count); end
`endif
    reset = 1'b1;
    step();
  endtask

  task automatic test_fault_free();
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", busy); end
    for (int r = 0; r <= NR; r++) begin drive_round(r, 4'h0); step(); end
    idle(); finish = 1'b1; step(); finish = 1'b0; step(); step();
    checks++;
    if (obs() !== 10'b00_0000_1111) begin
      errors++; $display("FAIL fault_free: got %b expected %b", obs(), 10'b00_0000_1111);
    end
  endtask

  task automatic test_sb_fault();
    start = 1'b1; step(); start = 1'b0;
    for (int r = 0; r < 4; r++) begin drive_round(r, 4'h0); step(); end
    drive_round(4, 4'h0);
    data_out_sb[8*5+3] = ~data_out_sb[8*5+3];
    cur_mask = 4'b0001;
    step();
    checks++;
    if (obs() !== 10'b10_0000_1111) begin
      errors++; $display("FAIL sb_latency: got %b expected %b", obs(), 10'b10_0000_1111);
    end
    idle(); step();
    checks++;
    if (obs() !== 10'b11_0001_0100) begin
      errors++; $display("FAIL sb_fault: got %b expected %b", obs(), 10'b11_0001_0100);
    end
    for (int r = 5; r <= NR; r++) begin drive_round(r, 4'h0); step(); end
    idle(); finish = 1'b1; step(); finish = 1'b0; step(); step();
    checks++;
    if (obs() !== 10'b01_0001_0100) begin
      errors++; $display("FAIL sb_hold_done: got %b expected %b", obs(), 10'b01_0001_0100);
    end
  endtask

  task automatic test_gating();
    start = 1'b1; step(); start = 1'b0;
    drive_round(NR, 4'b0100); step(); idle(); step(); step();
    checks++;
    if (obs() !== 10'b10_0000_1111) begin
      errors++; $display("FAIL gate_mx_last: got %b expected %b", obs(), 10'b10_0000_1111);
    end
    drive_round(0, 4'b1000); step(); idle(); step();
    checks++;
    if (obs() !== 10'b11_1000_0000) begin
      errors++; $display("FAIL gate_kx_r0: got %b expected %b", obs(), 10'b11_1000_0000);
    end
    finish = 1'b1; step(); finish = 1'b0;
  endtask

  task automatic test_multi();
    start = 1'b1; step(); start = 1'b0;
    drive_round(2, 4'b0010); step(); idle(); step(); step();
    drive_round(7, 4'b0100); finish = 1'b1; step(); idle(); step();
    checks++;
    if (obs() !== 10'b01_0110_0010) begin
      errors++; $display("FAIL multi_drain: got %b expected %b", obs(), 10'b01_0110_0010);
    end
`ifdef CED_FAULT_COUNT_EN
    checks++;
    if (fault_count !== CW'(2)) begin errors++; $display("FAIL multi_count: got %0d expected 2", fault_count); end
`endif
  endtask

  task automatic test_start_collision();
    start = 1'b1; step(); start = 1'b0;
    drive_round(3, 4'b0010); step();
    drive_round(5, 4'b0001); start = 1'b1; step(); idle();
    checks++;
    if (obs() !== 10'b10_0000_1111) begin
      errors++; $display("FAIL start_collide: got %b expected %b", obs(), 10'b10_0000_1111);
    end
    step();
    checks++;
    if (obs() !== 10'b10_0000_1111) begin
      errors++; $display("FAIL start_discard: got %b expected %b", obs(), 10'b10_0000_1111);
    end
  endtask

  task automatic test_mid_reset();
    drive_round(6, 4'b1000); step(); idle(); step();
    checks++;
    if (obs() !== 10'b11_1000_0110) begin
      errors++; $display("FAIL pre_reset: got %b expected %b", obs(), 10'b11_1000_0110);
    end
    drive_round(8, 4'b0001); reset = 1'b0; step(); reset = 1'b1; idle();
    checks++;
    if (obs() !== 10'b00_0000_1111) begin
      errors++; $display("FAIL mid_reset: got %b expected %b", obs(), 10'b00_0000_1111);
    end
    step();
    checks++;
    if (obs() !== 10'b00_0000_1111) begin
      errors++; $display("FAIL reset_pipe: got %b expected %b", obs(), 10'b00_0000_1111);
    end
`ifdef CED_FAULT_COUNT_EN
    checks++;
    if (fault_count !== CW'(0)) begin errors++; $display("FAIL reset_count2: got %0d expected 0", fault_count); end
`endif
  endtask

  task automatic test_ignored();
    drive_round(4, 4'b1111); step(); step(); idle(); step();
    checks++;
    if (obs() !== 10'b00_0000_1111) begin
      errors++; $display("FAIL idle_ignored: got %b expected %b", obs(), 10'b00_0000_1111);
    end
    start = 1'b1; step(); start = 1'b0;
    drive_round(4, 4'b0001); step(); idle(); finish = 1'b1; step(); finish = 1'b0;
    drive_round(6, 4'b1110); step(); step(); idle(); step();
    checks++;
    if (obs() !== 10'b01_0001_0100) begin
      errors++; $display("FAIL done_ignored: got %b expected %b", obs(), 10'b01_0001_0100);
    end
    start = 1'b1; step(); start = 1'b0;
    drive_round(12, 4'b1111); step(); step(); idle(); step();
    checks++;
    if (obs() !== 10'b10_0000_1111) begin
      errors++; $display("FAIL round12_ignored: got %b expected %b", obs(), 10'b10_0000_1111);
    end
    finish = 1'b1; step(); finish = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] fm;
    for (int it = 0; it < 600; it++) begin
      start  = (it == 0) || ($urandom_range(19, 0) == 0);
      finish = ($urandom_range(24, 0) == 0);
      reset  = ($urandom_range(149, 0) != 0);
      if ($urandom_range(2, 0) != 0) begin
        fm = ($urandom_range(4, 0) == 0) ? 4'($urandom_range(15, 1)) : 4'h0;
        drive_round(int'($urandom_range(12, 0)), fm);
      end else begin
        round_valid = 1'b0;
        cur_mask    = 4'h0;
      end
      step();
      checks++;
      if (obs() !== {m_act, m_det, m_loc, m_first}) begin
        errors++;
        $display("FAIL random[%0d]: got %b expected %b", it, obs(), {m_act, m_det, m_loc, m_first});
      end
`ifdef CED_FAULT_COUNT_EN
      checks++;
      if (fault_count !== CW'(m_cnt)) begin
        errors++; $display("FAIL random_count[%0d]: got %0d expected %0d", it, fault_count, m_cnt);
      end
`endif
    end
    reset = 1'b1;
    idle();
  endtask

  initial begin
    start = 1'b0;
    finish = 1'b0;
    cur_mask = 4'h0;
    m_act = 1'b0;
    model_clear();
    build_aes();
    test_reset();
    test_fault_free();
    test_sb_fault();
    test_gating();
    test_multi();
    test_start_collision();
    test_mid_reset();
    test_ignored();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
